mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - Memory stage of the single-cycle RISC-V core: consumes the EX results (ALU write data, effective
//   address, store data, instruction) and performs RV32I loads/stores against a handshaked data memory.
// - Registers the writeback triple (WriteReg/WriteDataNum/WriteData) for the register file and stalls
//   the front of the core while a memory transaction is in flight.
// PARAMETERS
// - TIMEOUT_CYCLES  16  max cycles in REQ+WAIT before bus error; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
// - clk             in   1   core clock, all state on rising edge
// - rst             in   1   synchronous, active-high reset
// - valid_i         in   1   EX presents a valid instruction this cycle
// - inst_i          in   32  instruction word; [6:0] opcode, [14:12] funct3
// - WriteReg_i      in   1   EX write-enable for rd
// - WriteDataNum_i  in   5   rd index
// - WriteData_i     in   32  ALU/link result (non-memory writeback value)
// - MemAddr_i       in   32  effective byte address
// - StoreData_i     in   32  rs2 value for stores
// - stall_o         out  1   hold EX/PC; combinational
// - valid_o         out  1   writeback triple valid (1-cycle pulse)
// - WriteReg_o      out  1   rd write enable to register file
// - WriteDataNum_o  out  5   rd index
// - WriteData_o     out  32  writeback value
// - exc_o           out  2   00 none, 01 misaligned, 10 illegal width, 11 bus timeout; valid with valid_o
// - dmem_req_o      out  1   request; held until dmem_gnt_i
// - dmem_we_o       out  1   1 = store
// - dmem_addr_o     out  32  word-aligned address {MemAddr[31:2],2'b00}
// - dmem_be_o       out  4   byte enables
// - dmem_wdata_o    out  32  lane-replicated store data
// - dmem_gnt_i      in   1   request accepted this cycle
// - dmem_rvalid_i   in   1   load data valid (same cycle as gnt or later)
// - dmem_rdata_i    in   32  load data word
// BEHAVIOUR
// - Reset: state IDLE, timeout counter 0, every output 0 (incl. dmem_*), captured operands 0.
// - FSM IDLE/REQ/WAIT/DONE. Mem op = opcode 0000011 (load) or 0100011 (store).
// - IDLE, valid_i, non-mem op: next cycle valid_o=1 with WriteReg/Num/Data_i registered; latency 1.
// - IDLE, valid_i, mem op: check funct3 (loads 0,1,2,4,5; stores 0,1,2; else exc 10) and alignment
//   (half addr[0]=1, word addr[1:0]!=0 -> exc 01). On exception: no dmem request; next cycle valid_o=1,
//   WriteReg_o=0, exc_o set. Otherwise capture operands, go REQ; stall_o=1 in this cycle.
// - REQ: dmem_req_o=1, we/addr/be/wdata stable until gnt. gnt: store -> DONE; load -> WAIT, or
//   DONE directly if rvalid in the same cycle.
// - WAIT: on rvalid capture extracted data -> DONE. rvalid outside REQ/WAIT is ignored.
// - DONE (1 cycle): valid_o=1; load WriteReg_o=captured WriteReg, data = extracted; store WriteReg_o=0.
//   stall_o=0; next state IDLE (new valid_i accepted from IDLE only).
// - stall_o = state in {REQ,WAIT} | (IDLE & valid_i & mem op & no exception).
// - Timeout: counter clears on REQ entry, increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES ->
//   drop request, DONE with WriteReg_o=0, exc_o=11. gnt/rvalid in the expiry cycle takes priority.
// - Byte lanes (o=addr[1:0]): SB be=0001<<o, wdata={4{d[7:0]}}; SH be=0011<<o, wdata={2{d[15:0]}};
//   SW be=1111, wdata=d. Loads: r=rdata>>(8*o); LB/LH sign-extend r[7:0]/r[15:0]; LBU/LHU zero-extend; LW=r.
// - Reset mid-transaction: immediate IDLE, dmem_req_o=0 next edge, late response ignored.
// - rd=0 passes through unchanged; register file ignores x0 writes.
// STRUCTURE
// - Package mem_access_pkg: OPC_LOAD/OPC_STORE, funct3 constants (F3_B/H/W/BU/HU), FSM state
//   localparams, exc_o codes.
// - Sub-module mem_lane_align (combinational): funct3+offset+data -> be/wdata; rdata -> extracted load.
// TESTING
// - ADD, WriteData_i=0x1234, rd=5 -> next cycle valid_o=1, WriteReg_o=1, Num=5, Data=0x1234, stall_o=0.
// - SB addr 0x103, d=0xAB, gnt after 2 cycles -> be=1000, wdata=0xABABABAB, addr=0x100, held; then DONE,
//   WriteReg_o=0.
// - LB addr 0x101, rdata=0x0000_80FF rvalid 3 cycles after gnt -> WriteData_o=0xFFFFFF80; LBU -> 0x80.
// - LH addr 0x102, gnt+rvalid same cycle, rdata=0x8001_0000 -> DONE next cycle, data 0xFFFF8001.
// - LW addr 0x106 -> no dmem_req_o, valid_o next cycle, exc_o=01, WriteReg_o=0; funct3=3 load -> exc 10.
// - No gnt for 16 cycles -> exc_o=11, WriteReg_o=0, req dropped; rst in WAIT -> IDLE, late rvalid ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory-access stage.
// Opcodes, funct3 widths, FSM states and exception codes.
package mem_access_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_MISAL = 2'b01;
  localparam logic [1:0] EXC_WIDTH = 2'b10;
  localparam logic [1:0] EXC_TMO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  // Width legality first, then natural alignment of the access.
  function automatic logic [1:0] mem_check(
    input logic       is_store,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic legal;
    logic misal;
    legal = 1'b0;
    misal = 1'b0;
    unique case (f3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1; misal = off[0]; end
      F3_W:  begin legal = 1'b1; misal = |off; end
      F3_BU: legal = !is_store;
      F3_HU: begin legal = !is_store; misal = off[0]; end
      default: legal = 1'b0;
    endcase
    if (!legal)
      return EXC_WIDTH;
    else if (misal)
      return EXC_MISAL;
    else
      return EXC_NONE;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction for loads.
// Purely combinational; funct3 and offset select the lanes.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [31:0] r;

  // Store side: enables shifted into place, data replicated on all lanes.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = sdata_i;
    unique case (f3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{sdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = sdata_i;
      end
    endcase
  end

  // Load side: shift addressed byte down, then sign/zero extend.
  always_comb begin
    r       = rdata_i >> {off_i, 3'b000};
    ldata_o = r;
    unique case (f3_i)
      F3_B:    ldata_o = {{24{r[7]}}, r[7:0]};
      F3_H:    ldata_o = {{16{r[15]}}, r[15:0]};
      F3_BU:   ldata_o = {24'h0, r[7:0]};
      F3_HU:   ldata_o = {16'h0, r[15:0]};
      default: ldata_o = r;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: RV32I loads/stores over a req/gnt/rvalid bus.
// Registers the writeback triple and stalls the front end.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic        WriteReg_i,
  input  logic [4:0]  WriteDataNum_i,
  input  logic [31:0] WriteData_i,
  input  logic [31:0] MemAddr_i,
  input  logic [31:0] StoreData_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic        WriteReg_o,
  output logic [4:0]  WriteDataNum_o,
  output logic [31:0] WriteData_o,
  output logic [1:0]  exc_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wcap_q, wcap_d;
  logic        valid_q, valid_d;
  logic        wreg_q, wreg_d;
  logic [4:0]  num_q, num_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  exc_q, exc_d;
  logic        stall;

  logic [6:0]  opc;
  logic        is_mem;
  logic        is_st;
  logic [1:0]  chk;
  logic        in_idle;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;
  logic        unused_inst;

  assign opc     = inst_i[6:0];
  assign is_st   = (opc == OPC_STORE);
  assign is_mem  = (opc == OPC_LOAD) || is_st;
  assign chk     = mem_check(is_st, inst_i[14:12], MemAddr_i[1:0]);
  assign in_idle = (state_q == S_IDLE);
  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

  // Store lanes are needed at accept, load extraction only later,
  // so one aligner serves both via the operand mux.
  mem_lane_align u_align (
    .f3_i    (in_idle ? inst_i[14:12] : f3_q),
    .off_i   (in_idle ? MemAddr_i[1:0] : off_q),
    .sdata_i (StoreData_i),
    .rdata_i (dmem_rdata_i),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .ldata_o (al_ldata)
  );

  // Next-state, operand capture and writeback result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wcap_d  = wcap_q;
    valid_d = 1'b0;
    wreg_d  = 1'b0;
    num_d   = num_q;
    data_d  = data_q;
    exc_d   = exc_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i && !is_mem) begin
          valid_d = 1'b1;
          wreg_d  = WriteReg_i;
          num_d   = WriteDataNum_i;
          data_d  = WriteData_i;
          exc_d   = EXC_NONE;
        end else if (valid_i && chk != EXC_NONE) begin
          valid_d = 1'b1;
          num_d   = WriteDataNum_i;
          data_d  = '0;
          exc_d   = chk;
        end else if (valid_i) begin
          stall   = 1'b1;
          we_d    = is_st;
          f3_d    = inst_i[14:12];
          off_d   = MemAddr_i[1:0];
          addr_d  = {MemAddr_i[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          wcap_d  = WriteReg_i;
          num_d   = WriteDataNum_i;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dmem_gnt_i) begin
          if (we_q) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            data_d  = '0;
            exc_d   = EXC_NONE;
          end else if (dmem_rvalid_i) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            wreg_d  = wcap_q;
            data_d  = al_ldata;
            exc_d   = EXC_NONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_q >= TMO_LAST) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          data_d  = '0;
          exc_d   = EXC_TMO;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dmem_rvalid_i) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          wreg_d  = wcap_q;
          data_d  = al_ldata;
          exc_d   = EXC_NONE;
        end else if (cnt_q >= TMO_LAST) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          data_d  = '0;
          exc_d   = EXC_TMO;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wcap_q  <= 1'b0;
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      num_q   <= '0;
      data_q  <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wcap_q  <= wcap_d;
      valid_q <= valid_d;
      wreg_q  <= wreg_d;
      num_q   <= num_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  assign stall_o        = stall;
  assign valid_o        = valid_q;
  assign WriteReg_o     = wreg_q;
  assign WriteDataNum_o = num_q;
  assign WriteData_o    = data_q;
  assign exc_o          = exc_q;
  assign dmem_req_o     = (state_q == S_REQ);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;

endmodule
